pp_lane_sequencer: RTL and testbench
====================================

Name: pp_lane_sequencer

Overview:
Sequences one shared partial-product generator (FP8 image 1-5-2 × 4-bit log weight) across a vector of LANES image/weight pairs. Accepts a whole vector on a valid/ready handshake and streams one registered partial product per cycle downstream with lane index and last flag. Also reports the maximum product exponent of the vector for downstream alignment. Sits between the activation/weight buffers and the MAC accumulator.

Parameters:
LANES, 8, image/weight pairs per vector (power of two, ≥2)
IDX_W, $clog2(LANES), lane index width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  vector valid
in_ready  out  1  vector accepted when in_valid&&in_ready
in_image  in  8*LANES  lane i at [8i+7:8i]; |S|E4..E0|M1 M0|
in_weight  in  4*LANES  lane i at [4i+3:4i]; |S|E2..E0|, E=3'b111 means zero
out_valid  out  1  lane result valid
out_ready  in  1  downstream accepts
out_pp  out  4  denormalised PP |S|1|M1 M0|, 0 if zero lane
out_exp  out  6  image_exp+weight_exp, 0 if zero lane
out_idx  out  IDX_W  lane index of out_pp
out_last  out  1  high with lane LANES-1
max_exp  out  6  max out_exp over non-zero lanes of last completed vector
max_exp_valid  out  1  one-cycle pulse when max_exp updates
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock clk; reset rst_n asynchronous, active-low. On reset all state cleared: state=IDLE, out_valid=0, out_pp=0, out_exp=0, out_idx=0, out_last=0, max_exp=0, max_exp_valid=0, busy=0; any in-flight vector discarded, no partial results emitted after release.
- Per-lane function: zero = (img[6:0]==0) || (wgt[2:0]==3'b111); sign = img[7]^wgt[3]; pp = zero ? 0 : {sign,1'b1,img[1:0]}; exp = zero ? 0 : {1'b0,img[6:2]} + {3'b0,wgt[2:0]} (6-bit, no overflow, max 37).
- States: IDLE, RUN, TAIL.
- IDLE: in_ready=1. On in_valid: latch in_image/in_weight into vector regs, lane counter=0, running max=0 -> RUN. in_ready=0 in RUN and TAIL; in_image/in_weight ignored there.
- RUN: output register loads when (!out_valid || out_ready): out_pp/out_exp from generator on lane[counter], out_idx=counter, out_last=(counter==LANES-1), out_valid=1; counter++; running max updated with exp if lane non-zero. Loading lane LANES-1 -> TAIL.
- TAIL: hold until last lane transfers (out_valid&&out_ready&&out_last): out_valid=0, max_exp<=running max (includes lane LANES-1), max_exp_valid=1 for exactly that next cycle -> IDLE.
- Latency: accept at edge N -> lane 0 out_valid after edge N+1. With out_ready held high: LANES consecutive output cycles, then 1 idle cycle before next in_ready; vector period LANES+2 cycles.
- Backpressure: while out_valid&&!out_ready, out_* stable, counter and running max frozen. No lane dropped or duplicated.
- Non-zero lane with exp 0 (img exp 0, wgt exp 0, mant≠0) counts toward max (value 0). All-zero vector -> max_exp=0, still pulses.
- max_exp holds its value until next vector completes.

Decomposition:
- Shared package: FP8 field positions (sign bit 7, exp [6:2], mant [1:0]), weight zero code 3'b111, PP width 4, exp width 6, state encoding enum {IDLE,RUN,TAIL}.
- One sub-module: existing PPgenerator instantiated once on the muxed lane; its cost output left unconnected. Lane mux, counter, FSM, output register and max tracker in this block.

Test Plan:
- LANES=8, lane0 img 0x3D wgt 0x2, others img 0x00 -> idx0: pp 4'b0101 exp 17; idx1..7: pp 0 exp 0; out_last on idx7; max_exp 17 pulsed once.
- Lane0 img 0x3D wgt 0xA; lane1 img 0xBD wgt 0xA -> pp 4'b1101 exp 17; pp 4'b0101 exp 17 (sign XOR).
- Zero cases: img 0x80 wgt 0x1; img 0x40 wgt 0x7; img 0x7F wgt 0x6 -> pp0/exp0, pp0/exp0, pp 4'b0111 exp 37; max_exp 37.
- out_ready low 3 cycles at idx3 -> out_pp/out_exp/out_idx=3 stable; all 8 lanes delivered once in order; max unchanged.
- Back-to-back vectors, out_ready=1 -> in_ready high in IDLE only; second accept exactly 10 cycles after first; max_exp_valid pulses once per vector.
- rst_n low during idx4 (async, mid-cycle) -> out_valid, busy, max_exp go 0 immediately; after release in_ready=1, no stale lanes emitted.

Source files
------------

// File: rtl/pp_lane_sequencer_pkg.sv
// Shared field layout, widths, lane result type and FSM encoding for the lane sequencer.
package pp_lane_sequencer_pkg;

  // FP8 image layout |S|E4..E0|M1 M0|
  localparam int IMG_SIGN    = 7;
  localparam int IMG_EXP_HI  = 6;
  localparam int IMG_EXP_LO  = 2;
  localparam int IMG_MANT_HI = 1;
  localparam int IMG_MANT_LO = 0;

  // 4-bit log weight |S|E2..E0|, all-ones exponent encodes zero
  localparam int WGT_SIGN   = 3;
  localparam int WGT_EXP_HI = 2;
  localparam logic [2:0] WGT_ZERO = 3'b111;

  localparam int PP_W  = 4;
  localparam int EXP_W = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_TAIL = 2'd2;

  typedef struct packed {
    logic             zero;
    logic [PP_W-1:0]  pp;
    logic [EXP_W-1:0] exp;
  } pp_res_t;

  function automatic logic [EXP_W-1:0] exp_max(input logic [EXP_W-1:0] a,
                                               input logic [EXP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pp_lane_sequencer_pp_gen.sv
// Purpose: FP8(1-5-2) x 4-bit log weight partial-product generator, one lane.
// Latency: combinational, 0 cycles.
// Backpressure: none; pure function of its inputs.
module pp_lane_sequencer_pp_gen
  import pp_lane_sequencer_pkg::*;
(
  input  logic [7:0] img,
  input  logic [3:0] wgt,
  output pp_res_t    res,
  output logic [1:0] cost
);

  logic zero;
  logic sign;

  assign zero = (img[IMG_EXP_HI:0] == 7'd0) || (wgt[WGT_EXP_HI:0] == WGT_ZERO);
  assign sign = img[IMG_SIGN] ^ wgt[WGT_SIGN];

  always_comb begin
    res = '0;
    res.zero = zero;
    if (!zero) begin
      res.pp  = {sign, 1'b1, img[IMG_MANT_HI:IMG_MANT_LO]};
      res.exp = {1'b0, img[IMG_EXP_HI:IMG_EXP_LO]} + {3'b000, wgt[WGT_EXP_HI:0]};
    end
  end

  // Activity estimate: shift-only lanes are cheaper than ones with mantissa bits set.
  always_comb begin
    cost = 2'd0;
    if (!zero) begin
      cost = 2'd1 + {1'b0, |img[IMG_MANT_HI:IMG_MANT_LO]};
    end
  end

endmodule

// File: rtl/pp_lane_sequencer.sv
// Purpose: time-multiplexes one PP generator over a LANES-wide image/weight vector, tracking max exponent.
// Latency: lane 0 valid one cycle after accept; vector period LANES+2 cycles with out_ready high.
// Backpressure: out_ready low freezes out_*, lane counter and running max; in_ready only in IDLE.
module pp_lane_sequencer
  import pp_lane_sequencer_pkg::*;
#(
  parameter int LANES = 8,
  parameter int IDX_W = $clog2(LANES)
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [8*LANES-1:0]   in_image,
  input  logic [4*LANES-1:0]   in_weight,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PP_W-1:0]      out_pp,
  output logic [EXP_W-1:0]     out_exp,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last,
  output logic [EXP_W-1:0]     max_exp,
  output logic                 max_exp_valid,
  output logic                 busy
);

  logic [1:0]           state;
  logic [8*LANES-1:0]   vec_image;
  logic [4*LANES-1:0]   vec_weight;
  logic [IDX_W-1:0]     cnt;
  logic [EXP_W-1:0]     run_max;
  logic [7:0]           lane_img;
  logic [3:0]           lane_wgt;
  pp_res_t              gen_res;
  logic                 load_en;
  logic                 last_lane;
  logic                 tail_done;

  always_comb begin
    lane_img = '0;
    lane_wgt = '0;
    for (int i = 0; i < LANES; i++) begin
      if (cnt == IDX_W'(i)) begin
        lane_img = vec_image[8*i +: 8];
        lane_wgt = vec_weight[4*i +: 4];
      end
    end
  end

  pp_lane_sequencer_pp_gen u_pp_gen (
    .img  (lane_img),
    .wgt  (lane_wgt),
    .res  (gen_res),
    .cost ()
  );

  assign in_ready  = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign load_en   = (state == ST_RUN) && (!out_valid || out_ready);
  assign last_lane = (cnt == IDX_W'(LANES - 1));
  assign tail_done = (state == ST_TAIL) && out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      vec_image  <= '0;
      vec_weight <= '0;
      cnt        <= '0;
      run_max    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            vec_image  <= in_image;
            vec_weight <= in_weight;
            cnt        <= '0;
            run_max    <= '0;
            state      <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_en) begin
            cnt <= cnt + 1'b1;
            // Zero lanes are excluded, but a genuine exponent of 0 still counts.
            if (!gen_res.zero) begin
              run_max <= exp_max(run_max, gen_res.exp);
            end
            if (last_lane) begin
              state <= ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (tail_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_pp        <= '0;
      out_exp       <= '0;
      out_idx       <= '0;
      out_last      <= 1'b0;
      max_exp       <= '0;
      max_exp_valid <= 1'b0;
    end else begin
      max_exp_valid <= 1'b0;
      if (load_en) begin
        out_valid <= 1'b1;
        out_pp    <= gen_res.pp;
        out_exp   <= gen_res.exp;
        out_idx   <= cnt;
        out_last  <= last_lane;
      end else if (tail_done) begin
        out_valid     <= 1'b0;
        max_exp       <= run_max;
        max_exp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pp_lane_sequencer.sv
// Directed bench for pp_lane_sequencer: lane products, sign, zero codes, stalls, throughput and async reset.
module tb_pp_lane_sequencer;

  localparam int LANES = 8;
  localparam int IDX_W = 3;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [8*LANES-1:0] in_image;
  logic [4*LANES-1:0] in_weight;
  logic               out_valid;
  logic               out_ready;
  logic [3:0]         out_pp;
  logic [5:0]         out_exp;
  logic [IDX_W-1:0]   out_idx;
  logic               out_last;
  logic [5:0]         max_exp;
  logic               max_exp_valid;
  logic               busy;

  int checks = 0;
  int passes = 0;

  logic [3:0] rec_pp   [16];
  logic [5:0] rec_exp  [16];
  logic [2:0] rec_idx  [16];
  logic       rec_last [16];
  int         rec_n;
  int         pulses;
  logic [5:0] rec_max;
  int         stall_bad;
  int         stall_seen;

  logic [3:0] want_pp  [LANES];
  logic [5:0] want_exp [LANES];

  pp_lane_sequencer #(.LANES(LANES), .IDX_W(IDX_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_image      (in_image),
    .in_weight     (in_weight),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pp        (out_pp),
    .out_exp       (out_exp),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .max_exp       (max_exp),
    .max_exp_valid (max_exp_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offers a vector from a negedge and returns at the negedge after it was accepted.
  task automatic send_vector(input logic [8*LANES-1:0] img, input logic [4*LANES-1:0] wgt);
    int guard;
    in_image  = img;
    in_weight = wgt;
    in_valid  = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      $display("FAIL send_timeout in_ready stayed %b, required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Drains one vector, optionally stalling 3 cycles on lane stall_idx, and records what was seen.
  task automatic collect(input int stall_idx);
    logic [3:0] ref_pp;
    logic [5:0] ref_exp;
    logic [2:0] ref_idx;
    int         left;
    bit         have_ref;
    rec_n = 0; pulses = 0; stall_bad = 0; stall_seen = 0; left = 3; have_ref = 0;
    ref_pp = '0; ref_exp = '0; ref_idx = '0;
    for (int cyc = 0; cyc < 80 && (rec_n < LANES || pulses == 0); cyc++) begin
      out_ready = 1'b1;
      if (stall_idx >= 0 && out_valid && int'(out_idx) == stall_idx) begin
        if (!have_ref) begin
          ref_pp = out_pp; ref_exp = out_exp; ref_idx = out_idx; have_ref = 1;
        end else if (out_pp !== ref_pp || out_exp !== ref_exp || out_idx !== ref_idx) begin
          stall_bad++;
        end
        if (left > 0) begin
          out_ready = 1'b0;
          left--;
          stall_seen++;
        end
      end
      if (out_valid && out_ready) begin
        if (rec_n < 16) begin
          rec_pp[rec_n] = out_pp; rec_exp[rec_n] = out_exp;
          rec_idx[rec_n] = out_idx; rec_last[rec_n] = out_last;
        end
        rec_n++;
      end
      if (max_exp_valid) begin
        pulses++;
        rec_max = max_exp;
      end
      @(negedge clk);
    end
    if (rec_n < LANES || pulses == 0) begin
      checks++;
      $display("FAIL collect_timeout lanes=%0d pulses=%0d, required %0d lanes and a pulse", rec_n, pulses, LANES);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({out_valid, out_pp, out_exp, out_idx, out_last, max_exp, max_exp_valid, busy} !== '0) begin
      $display("FAIL reset_outputs got valid=%b pp=%h exp=%0d idx=%0d last=%b max=%0d mv=%b busy=%b, required all 0",
               out_valid, out_pp, out_exp, out_idx, out_last, max_exp, max_exp_valid, busy);
    end else passes++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_idle got in_ready=%b busy=%b, required 1/0", in_ready, busy);
    end else passes++;
  endtask

  task automatic test_single_lane();
    logic [8*LANES-1:0] img;
    logic [4*LANES-1:0] wgt;
    img = '0; wgt = '0;
    img[7:0] = 8'h3D; wgt[3:0] = 4'h2;
    for (int i = 0; i < LANES; i++) begin
      want_pp[i] = 4'b0000; want_exp[i] = 6'd0;
    end
    want_pp[0] = 4'b0101; want_exp[0] = 6'd17;
    send_vector(img, wgt);
    collect(-1);
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if (rec_pp[i] !== want_pp[i] || rec_exp[i] !== want_exp[i] || rec_idx[i] !== 3'(i) || rec_last[i] !== (i == LANES-1)) begin
        $display("FAIL single_lane%0d got pp=%b exp=%0d idx=%0d last=%b, required pp=%b exp=%0d idx=%0d last=%b",
                 i, rec_pp[i], rec_exp[i], rec_idx[i], rec_last[i], want_pp[i], want_exp[i], i, (i == LANES-1));
      end else passes++;
    end
    checks++;
    if (pulses !== 1 || rec_max !== 6'd17) begin
      $display("FAIL single_max got pulses=%0d max=%0d, required 1/17", pulses, rec_max);
    end else passes++;
    checks++;
    if (max_exp_valid !== 1'b0 || max_exp !== 6'd17 || busy !== 1'b0) begin
      $display("FAIL single_hold got mv=%b max=%0d busy=%b, required 0/17/0", max_exp_valid, max_exp, busy);
    end else passes++;
  endtask

  task automatic test_sign();
    logic [8*LANES-1:0] img;
    logic [4*LANES-1:0] wgt;
    img = '0; wgt = '0;
    img[7:0] = 8'h3D; wgt[3:0] = 4'hA;
    img[15:8] = 8'hBD; wgt[7:4] = 4'hA;
    send_vector(img, wgt);
    collect(-1);
    checks++;
    if (rec_pp[0] !== 4'b1101 || rec_exp[0] !== 6'd17) begin
      $display("FAIL sign_lane0 got pp=%b exp=%0d, required 1101/17", rec_pp[0], rec_exp[0]);
    end else passes++;
    checks++;
    if (rec_pp[1] !== 4'b0101 || rec_exp[1] !== 6'd17) begin
      $display("FAIL sign_lane1 got pp=%b exp=%0d, required 0101/17", rec_pp[1], rec_exp[1]);
    end else passes++;
    checks++;
    if (rec_max !== 6'd17 || pulses !== 1) begin
      $display("FAIL sign_max got max=%0d pulses=%0d, required 17/1", rec_max, pulses);
    end else passes++;
  endtask

  task automatic test_zero_cases();
    logic [8*LANES-1:0] img;
    logic [4*LANES-1:0] wgt;
    img = '0; wgt = '0;
    img[7:0]   = 8'h80; wgt[3:0]   = 4'h1;
    img[15:8]  = 8'h40; wgt[7:4]   = 4'h7;
    img[23:16] = 8'h7F; wgt[11:8]  = 4'h6;
    send_vector(img, wgt);
    collect(-1);
    checks++;
    if (rec_pp[0] !== 4'b0000 || rec_exp[0] !== 6'd0) begin
      $display("FAIL zero_img got pp=%b exp=%0d, required 0000/0", rec_pp[0], rec_exp[0]);
    end else passes++;
    checks++;
    if (rec_pp[1] !== 4'b0000 || rec_exp[1] !== 6'd0) begin
      $display("FAIL zero_wgt got pp=%b exp=%0d, required 0000/0", rec_pp[1], rec_exp[1]);
    end else passes++;
    checks++;
    if (rec_pp[2] !== 4'b0111 || rec_exp[2] !== 6'd37) begin
      $display("FAIL max_exp_lane got pp=%b exp=%0d, required 0111/37", rec_pp[2], rec_exp[2]);
    end else passes++;
    checks++;
    if (rec_max !== 6'd37) begin
      $display("FAIL zero_max got %0d, required 37", rec_max);
    end else passes++;
  endtask

  task automatic test_backpressure();
    logic [8*LANES-1:0] img;
    logic [4*LANES-1:0] wgt;
    img = '0; wgt = '0;
    // Lane i: exponent i+1, mantissa i mod 4, weight exponent 0 -> exp i+1, pp {0,1,i[1:0]}.
    for (int i = 0; i < LANES; i++) begin
      img[8*i +: 8] = {1'b0, 5'(i + 1), 2'(i)};
    end
    send_vector(img, wgt);
    collect(3);
    checks++;
    if (stall_seen !== 3 || stall_bad !== 0) begin
      $display("FAIL stall_stable got stalls=%0d unstable=%0d, required 3/0", stall_seen, stall_bad);
    end else passes++;
    checks++;
    if (rec_n !== LANES) begin
      $display("FAIL stall_count got %0d lanes, required %0d", rec_n, LANES);
    end else passes++;
    for (int i = 0; i < LANES; i++) begin
      checks++;
      if (rec_idx[i] !== 3'(i) || rec_exp[i] !== 6'(i + 1) || rec_pp[i] !== {2'b01, 2'(i)}) begin
        $display("FAIL stall_lane%0d got idx=%0d exp=%0d pp=%b, required idx=%0d exp=%0d pp=%b",
                 i, rec_idx[i], rec_exp[i], rec_pp[i], i, i + 1, {2'b01, 2'(i)});
      end else passes++;
    end
    checks++;
    if (rec_max !== 6'd8 || pulses !== 1) begin
      $display("FAIL stall_max got max=%0d pulses=%0d, required 8/1", rec_max, pulses);
    end else passes++;
  endtask

  task automatic test_reset_mid();
    logic [8*LANES-1:0] img;
    logic [4*LANES-1:0] wgt;
    int guard;
    int stale;
    img = '0; wgt = '0;
    img[7:0] = 8'h3D; wgt[3:0] = 4'h2;
    img[39:32] = 8'h7F; wgt[19:16] = 4'h0;
    send_vector(img, wgt);
    out_ready = 1'b1;
    guard = 0;
    while (!(out_valid && out_idx == 3'd4) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      $display("FAIL rstmid_reach got idx=%0d valid=%b, required idx 4 valid", out_idx, out_valid);
    end else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || max_exp !== 6'd0 || out_idx !== 3'd0) begin
      $display("FAIL rstmid_clear got valid=%b busy=%b max=%0d idx=%0d, required 0/0/0/0", out_valid, busy, max_exp, out_idx);
    end else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_valid || max_exp_valid) stale++;
    end
    checks++;
    if (stale !== 0 || in_ready !== 1'b1) begin
      $display("FAIL rstmid_stale got stale=%0d in_ready=%b, required 0/1", stale, in_ready);
    end else passes++;
  endtask

  task automatic test_back_to_back();
    logic [8*LANES-1:0] img_a, img_b;
    logic [4*LANES-1:0] wgt_a, wgt_b;
    int acc, acc_cyc[2], pulse_n, lanes_seen, ready_bad;
    logic [5:0] maxes[4];
    logic [3:0] b_pp5;
    bit swap;
    img_a = '0; wgt_a = '0; img_b = '0; wgt_b = '0;
    img_a[7:0] = 8'h3D; wgt_a[3:0] = 4'h2;
    // Non-zero lane whose product exponent is 0: must still be a real product, max 0.
    img_b[47:40] = 8'h01; wgt_b[23:20] = 4'h0;
    acc = 0; pulse_n = 0; lanes_seen = 0; ready_bad = 0; swap = 0; b_pp5 = '0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    for (int k = 0; k < 4; k++) maxes[k] = '0;
    out_ready = 1'b1;
    in_image = img_a; in_weight = wgt_a; in_valid = 1'b1;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (swap) begin
        if (acc == 1) begin
          in_image = img_b; in_weight = wgt_b;
        end else begin
          in_valid = 1'b0;
        end
        swap = 0;
      end
      if (in_ready !== !busy) ready_bad++;
      if (in_valid && in_ready) begin
        if (acc < 2) acc_cyc[acc] = cyc;
        acc++;
        swap = 1;
      end
      if (out_valid) lanes_seen++;
      if (out_valid && out_idx == 3'd5 && acc == 2) b_pp5 = out_pp;
      if (max_exp_valid) begin
        if (pulse_n < 4) maxes[pulse_n] = max_exp;
        pulse_n++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (acc !== 2 || acc_cyc[1] - acc_cyc[0] !== 10) begin
      $display("FAIL b2b_period got accepts=%0d spacing=%0d, required 2/10", acc, acc_cyc[1] - acc_cyc[0]);
    end else passes++;
    checks++;
    if (ready_bad !== 0 || lanes_seen !== 16) begin
      $display("FAIL b2b_flow got ready_bad=%0d lanes=%0d, required 0/16", ready_bad, lanes_seen);
    end else passes++;
    checks++;
    if (pulse_n !== 2 || maxes[0] !== 6'd17 || maxes[1] !== 6'd0) begin
      $display("FAIL b2b_max got pulses=%0d max0=%0d max1=%0d, required 2/17/0", pulse_n, maxes[0], maxes[1]);
    end else passes++;
    checks++;
    if (b_pp5 !== 4'b0101) begin
      $display("FAIL b2b_exp0_lane got pp=%b, required 0101", b_pp5);
    end else passes++;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_image  = '0;
    in_weight = '0;
    rst_n     = 1'b0;
    test_reset();
    test_single_lane();
    test_sign();
    test_zero_cases();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
